// File: rtl/fact_master_if.sv
// Request/response channels and accelerator register bus for fact_master.
// Request and response channels use valid/ready: a transfer happens on a rising edge where both are high.
interface fact_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_n;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        resp_timeout;
  logic [1:0]  A;
  logic        WE;
  logic [3:0]  WD;
  logic [31:0] RD;

  modport master (
    input  req_valid, req_n, resp_ready, RD,
    output req_ready, resp_valid, resp_result, resp_err, resp_timeout, A, WE, WD
  );

  modport slave (
    output req_valid, req_n, resp_ready, RD,
    input  req_ready, resp_valid, resp_result, resp_err, resp_timeout, A, WE, WD
  );
endinterface

// File: rtl/fact_master.sv
// Bus initiator for the factorial accelerator: write n, pulse go, poll status,
// read result, clear go, then hand the outcome back on the response channel.
module fact_master #(
  parameter int POLL_TIMEOUT = 1024,
  parameter int CW           = 11
) (
  input  logic          clk,
  input  logic          rst,
  fact_master_if.master bus,
  output logic          busy,
  output logic [2:0]    state_dbg,
  output logic [3:0]    n_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_N, S_WR_GO, S_POLL, S_RD_RES, S_CLR_GO, S_RESP
  } state_t;

  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_TIMEOUT - 1);

  state_t        state;
  logic [3:0]    n_q;
  logic [CW-1:0] poll_cnt;
  logic [1:0]    a_q;
  logic          we_q;
  logic [3:0]    wd_q;
  logic          resp_valid_q;
  logic [31:0]   result_q;
  logic          err_q;
  logic          timeout_q;

  // Bus outputs are registered one state ahead so they are valid for the whole state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      n_q          <= '0;
      poll_cnt     <= '0;
      a_q          <= '0;
      we_q         <= 1'b0;
      wd_q         <= '0;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            n_q       <= bus.req_n;
            result_q  <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            a_q       <= 2'd0;
            we_q      <= 1'b1;
            wd_q      <= bus.req_n;
            state     <= S_WR_N;
          end
        end
        S_WR_N: begin
          a_q   <= 2'd1;
          we_q  <= 1'b1;
          wd_q  <= 4'b0001;
          state <= S_WR_GO;
        end
        S_WR_GO: begin
          a_q      <= 2'd2;
          we_q     <= 1'b0;
          wd_q     <= '0;
          poll_cnt <= '0;
          state    <= S_POLL;
        end
        S_POLL: begin
          // Error outranks done; both outrank the timeout.
          if (bus.RD[1]) begin
            err_q    <= 1'b1;
            result_q <= '0;
            a_q      <= 2'd1;
            we_q     <= 1'b1;
            wd_q     <= 4'b0000;
            state    <= S_CLR_GO;
          end else if (bus.RD[0]) begin
            a_q   <= 2'd3;
            state <= S_RD_RES;
          end else if (poll_cnt == POLL_LAST) begin
            timeout_q <= 1'b1;
            result_q  <= '0;
            a_q       <= 2'd1;
            we_q      <= 1'b1;
            wd_q      <= 4'b0000;
            state     <= S_CLR_GO;
          end else begin
            poll_cnt <= poll_cnt + CW'(1);
          end
        end
        S_RD_RES: begin
          result_q <= bus.RD;
          a_q      <= 2'd1;
          we_q     <= 1'b1;
          wd_q     <= 4'b0000;
          state    <= S_CLR_GO;
        end
        S_CLR_GO: begin
          a_q          <= 2'd0;
          we_q         <= 1'b0;
          wd_q         <= '0;
          resp_valid_q <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          a_q          <= '0;
          we_q         <= 1'b0;
          wd_q         <= '0;
          resp_valid_q <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = (state == S_IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_result  = result_q;
  assign bus.resp_err     = err_q;
  assign bus.resp_timeout = timeout_q;
  assign bus.A            = a_q;
  assign bus.WE           = we_q;
  assign bus.WD           = wd_q;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
  assign n_dbg     = n_q;

endmodule

// File: tb/tb_fact_master.sv
// Bench for fact_master: accelerator register model on the bus, directed and
// random transactions checked against an arithmetic factorial reference.
module tb_fact_master;
  localparam int PT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] state_dbg;
  logic [3:0] n_dbg;

  fact_master_if bus();

  fact_master #(.POLL_TIMEOUT(PT), .CW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg),
    .n_dbg     (n_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- accelerator register model ----------------
  int          m_lat   = 0;
  bit          m_never = 1'b0;
  logic [3:0]  m_n     = '0;
  logic        m_go    = 1'b0;
  logic [1:0]  m_st    = '0;
  logic [31:0] m_res   = '0;
  int          m_cnt   = 0;
  bit          m_run   = 1'b0;

  function automatic logic [31:0] fact_tbl(input logic [3:0] n);
    case (n)
      4'd0, 4'd1: fact_tbl = 32'd1;
      4'd2:  fact_tbl = 32'd2;
      4'd3:  fact_tbl = 32'd6;
      4'd4:  fact_tbl = 32'd24;
      4'd5:  fact_tbl = 32'd120;
      4'd6:  fact_tbl = 32'd720;
      4'd7:  fact_tbl = 32'd5040;
      4'd8:  fact_tbl = 32'd40320;
      4'd9:  fact_tbl = 32'd362880;
      4'd10: fact_tbl = 32'd3628800;
      4'd11: fact_tbl = 32'd39916800;
      4'd12: fact_tbl = 32'd479001600;
      default: fact_tbl = 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.WE && bus.A == 2'd0) m_n <= bus.WD;
    if (bus.WE && bus.A == 2'd1) begin
      m_go <= bus.WD[0];
      if (bus.WD[0]) begin
        m_st  <= 2'b00;
        m_res <= '0;
        m_cnt <= m_lat;
        m_run <= !m_never;
      end
    end else if (m_run) begin
      if (m_cnt == 0) begin
        m_run <= 1'b0;
        if (m_n > 4'd12) m_st <= {1'b1, m_n[0]};
        else begin
          m_st  <= 2'b01;
          m_res <= fact_tbl(m_n);
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign bus.RD = (bus.A == 2'd0) ? {28'd0, m_n} :
                  (bus.A == 2'd1) ? {31'd0, m_go} :
                  (bus.A == 2'd2) ? {30'd0, m_st} : m_res;

  // ---------------- bus monitor / scoreboard ----------------
  logic [5:0] exp_q[$];
  logic [5:0] wr_q[$];
  int polls = 0;
  int rds   = 0;

  always @(negedge clk) begin
    if (!rst && busy) begin
      if (bus.WE) wr_q.push_back({bus.A, bus.WD});
      if (!bus.WE && bus.A == 2'd2) polls++;
      if (bus.A == 2'd3) rds++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_r   = 0;
  int last_t   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned ref_fact(input int n);
    longint unsigned p = 1;
    for (int i = 2; i <= n; i++) p = p * longint'(i);
    return p;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after the response was taken.
  task automatic do_txn(input logic [3:0] n, input int lat, input bit never, input int hold);
    longint unsigned f;
    bit          e;
    logic [31:0] er;
    logic [5:0]  x;
    int t, r, k, g, exp_lat;
    f       = ref_fact(int'(n));
    e       = !never && (f > 64'hFFFF_FFFF);
    er      = (never || e) ? 32'd0 : f[31:0];
    k       = lat + 1;
    exp_lat = never ? 4 + PT : (e ? 5 + k : 6 + k);
    m_lat   = lat;
    m_never = never;
    exp_q.delete();
    exp_q.push_back({2'd0, n});
    exp_q.push_back({2'd1, 4'd1});
    exp_q.push_back({2'd1, 4'd0});
    wr_q.delete();
    polls = 0;
    rds   = 0;
    bus.resp_ready = (hold == 0);
    bus.req_n      = n;
    bus.req_valid  = 1'b1;
    g = 0;
    while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
    chk("accept_wait", g < 50, 1);
    t = cyc;
    last_t = t;
    @(negedge clk);
    if (hold > 0) bus.req_n = ~n;
    else bus.req_valid = 1'b0;
    g = 0;
    while (!bus.resp_valid && g < 200) begin @(negedge clk); g++; end
    chk("resp_wait", g < 200, 1);
    r = cyc;
    chk("latency", r - t, exp_lat);
    chk("result", bus.resp_result, er);
    chk("err", bus.resp_err, e);
    chk("timeout", bus.resp_timeout, never);
    chk("n_held", n_dbg, n);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_result", bus.resp_result, er);
      chk("hold_flags", {bus.resp_err, bus.resp_timeout}, {e, never});
      chk("hold_req_ready", bus.req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    last_r = cyc;
    @(negedge clk);
    chk("resp_drop", bus.resp_valid, 0);
    chk("idle_ready", bus.req_ready, 1);
    chk("polls", polls, never ? PT : k + 1);
    chk("rd_res", rds, (never || e) ? 0 : 1);
    chk("write_count", wr_q.size(), 3);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (wr_q.size() > 0) chk("bus_write", wr_q.pop_front(), x);
    end
    chk("go_cleared", m_go, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int prev_r, g, seen;
    bus.req_valid  = 1'b0;
    bus.req_n      = '0;
    bus.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_A", bus.A, 0);
    chk("rst_WE", bus.WE, 0);
    chk("rst_WD", bus.WD, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_result", bus.resp_result, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", busy, 0);

    // nominal 5! with a short accelerator latency
    do_txn(4'd5, 2, 1'b0, 0);

    // back-to-back: 0! then 12!, second accepted the cycle after the response
    do_txn(4'd0, 0, 1'b0, 0);
    prev_r = last_r;
    do_txn(4'd12, 4, 1'b0, 0);
    chk("b2b_accept", last_t, prev_r + 1);

    // overflowing operand reported as an error
    do_txn(4'd13, 3, 1'b0, 0);
    do_txn(4'd14, 0, 1'b0, 0);

    // status never set
    do_txn(4'd10, 0, 1'b1, 0);

    // consumer stalls for 10 cycles with a competing request pending
    do_txn(4'd6, 1, 1'b0, 10);

    // reset in the middle of polling
    m_lat   = 0;
    m_never = 1'b1;
    bus.req_n     = 4'd9;
    bus.req_valid = 1'b1;
    g = 0;
    while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
    chk("rst_accept_wait", g < 50, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_poll", bus.A, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_A", bus.A, 0);
    chk("async_WE", bus.WE, 0);
    chk("async_WD", bus.WD, 0);
    chk("async_resp", {bus.resp_valid, bus.resp_err, bus.resp_timeout}, 0);
    chk("async_result", bus.resp_result, 0);
    chk("async_busy", busy, 0);
    chk("async_n", n_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    wr_q.delete();
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.resp_valid || busy) seen++;
    end
    chk("no_resp_after_rst", seen, 0);
    chk("no_writes_after_rst", wr_q.size(), 0);
    do_txn(4'd3, 1, 1'b0, 0);

    // random traffic
    for (int i = 0; i < 20; i++) begin
      do_txn(4'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
             ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
